multdiv_sequencer: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage. It consumes the 5-bit ALU opcode selected by the execute-stage opcode mux, together with the two register operands. It runs a 32-iteration shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. It presents the result with a one-cycle ready pulse and an exception flag that feeds the status-register write path.

---
 rtl/multdiv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed 32-bit multiply / restoring divide.
// The unit accepts an op in IDLE and runs 32 iterations on operand
// magnitudes in RUN. It then applies the result sign and raises ready for
// one cycle in DONE. stall holds the front of the pipe while an op is in
// flight.
//
// Handshake: start (valid & a mult/div opcode) is sampled only in IDLE.
// The instruction is held by stall until DONE. In DONE, stall drops and
// ready pulses for exactly one cycle, so the held instruction advances on
// the same edge that returns the unit to IDLE. There is no back-pressure on
// ready. result and exception are valid only while ready is high.
module multdiv_sequencer #(
    parameter logic [4:0] OP_MULT = 5'b00110,
    parameter logic [4:0] OP_DIV  = 5'b00111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [4:0]  opcode,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        stall,
    output logic        ready,
    output logic [31:0] result,
    output logic        exception,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic        is_div;   // latched op type: 1 = divide
    logic        neg;      // latched result sign
    logic        div_ovf;  // latched 0x80000000 / -1 case
    logic [63:0] acc;      // mult: product accumulator; div: {remainder, quotient}
    logic [31:0] addend;   // mult: |multiplicand|; div: |divisor|
    logic [31:0] mplier;   // mult: |multiplier|, shifted right each iteration

    logic        start;
    logic        op_is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_next;

    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic        mul_ovf;

    // Decode the incoming instruction and form operand magnitudes.
    always_comb begin
        op_is_div = (opcode == OP_DIV);
        start     = valid & ((opcode == OP_MULT) | (opcode == OP_DIV));
        mag_a     = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
        mag_b     = operand_b[31] ? (~operand_b + 32'd1) : operand_b;
    end

    // One shift-add multiply step: add into the upper half, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, addend} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end

    // One restoring divide step: shift {rem, quo} left, trial-subtract the divisor.
    // The remainder stays below the divisor (at most 2^31), so the shifted
    // remainder fits in 32 bits and bit 32 of the difference is the borrow.
    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, addend};
        if (div_diff[32]) begin
            div_next = {div_shift[31:0], acc[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
        end
        step_next = is_div ? div_next : mul_next;
    end

    // Signed results derived from the final iteration's magnitude result.
    always_comb begin
        prod_signed = neg ? (~mul_next + 64'd1) : mul_next;
        quo_signed  = neg ? (~div_next[31:0] + 32'd1) : div_next[31:0];
        mul_ovf     = (prod_signed[63:32] != {32{prod_signed[31]}});
    end

    // stall covers the accepting cycle in IDLE plus every RUN cycle.
    always_comb begin
        stall       = ((state == IDLE) & start) | (state == RUN);
        debug_state = state;
    end

    // Sequencer FSM with registered ready/result/exception.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 5'd0;
            is_div    <= 1'b0;
            neg       <= 1'b0;
            div_ovf   <= 1'b0;
            acc       <= 64'd0;
            addend    <= 32'd0;
            mplier    <= 32'd0;
            ready     <= 1'b0;
            result    <= 32'd0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        is_div  <= op_is_div;
                        neg     <= operand_a[31] ^ operand_b[31];
                        div_ovf <= (operand_a == 32'h8000_0000) & (operand_b == 32'hFFFF_FFFF);
                        addend  <= op_is_div ? mag_b : mag_a;
                        mplier  <= mag_b;
                        acc     <= op_is_div ? {32'd0, mag_a} : 64'd0;
                        count   <= 5'd0;
                        if (op_is_div && (operand_b == 32'd0)) begin
                            // Divide by zero skips the iterations entirely.
                            state     <= DONE;
                            ready     <= 1'b1;
                            result    <= 32'd0;
                            exception <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc    <= step_next;
                    mplier <= {1'b0, mplier[31:1]};
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        state     <= DONE;
                        ready     <= 1'b1;
                        result    <= is_div ? quo_signed : prod_signed[31:0];
                        exception <= is_div ? div_ovf : mul_ovf;
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed testbench for multdiv_sequencer with hand-computed expectations.
module tb_multdiv_sequencer;

  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [4:0]  opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall;
  logic        ready;
  logic [31:0] result;
  logic        exception;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_sequencer #(.OP_MULT(OP_MULT), .OP_DIV(OP_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .stall       (stall),
    .ready       (ready),
    .result      (result),
    .exception   (exception),
    .debug_state (debug_state)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issues one op, then scrambles the inputs after acceptance; measures
  // latency from the accepting edge and counts stall cycles.
  task automatic run_op(input string tag, input logic [4:0] opc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int exp_stall);
    int stall_cnt;
    int lat;
    logic [32:0] exp;
    exp_q.push_back({exp_exc, exp_res});
    @(negedge clock);
    valid = 1'b1; opcode = opc; operand_a = a; operand_b = b;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clock);                    // E0: start sampled
    @(negedge clock);
    valid = 1'b0; opcode = OP_DIV;
    operand_a = $urandom; operand_b = $urandom_range(0, 3);
    #1;
    lat = 1;
    while (ready !== 1'b1 && lat < 200) begin
      if (stall) stall_cnt++;
      @(negedge clock);
      lat++;
    end
    exp = exp_q.pop_front();
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " stall_cycles"}, stall_cnt, exp_stall);
    check({tag, " stall_at_ready"}, stall, 0);
    check({tag, " result"}, result, exp[31:0]);
    check({tag, " exception"}, exception, exp[32]);
    @(negedge clock);
    check({tag, " ready_one_cycle"}, ready, 0);
  endtask

  // Holds an idle-type input pattern for n cycles; any stall/ready is an error.
  task automatic idle_pattern(input string tag, input logic v, input logic [4:0] opc, input int n);
    logic seen;
    seen = 1'b0;
    @(negedge clock);
    valid = v; opcode = opc; operand_a = 32'd9; operand_b = 32'd3;
    for (int i = 0; i < n; i++) begin
      #1;
      seen = seen | stall | ready;
      @(negedge clock);
    end
    check({tag, " stall_or_ready"}, seen, 0);
    check({tag, " state"}, debug_state, ST_IDLE);
    valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int t1;
    int t2;
    reset = 1'b1; valid = 1'b0; opcode = 5'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset state", debug_state, ST_IDLE);
    check("reset stall", stall, 0);
    check("reset ready", ready, 0);
    check("reset result", result, 0);
    check("reset exception", exception, 0);
    reset = 1'b0;

    run_op("mul 7*-6",        OP_MULT, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33, 33);
    run_op("mul ovf 2^16sq",  OP_MULT, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33, 33);
    run_op("mul ovf max*2",   OP_MULT, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33, 33);
    run_op("mul -3*-5",       OP_MULT, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 32'd15,        1'b0, 33, 33);
    run_op("mul min*1",       OP_MULT, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33, 33);
    run_op("div -7/2",        OP_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33, 33);
    run_op("div 100/7",       OP_DIV,  32'd100,        32'd7,         32'd14,        1'b0, 33, 33);
    run_op("div -100/7",      OP_DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 33, 33);
    run_op("div min/-1",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 33);
    run_op("div 5/0",         OP_DIV,  32'd5,          32'd0,         32'd0,         1'b1, 1,  1);

    // Asynchronous reset mid-RUN at iteration 10.
    @(negedge clock);
    valid = 1'b1; opcode = OP_MULT; operand_a = 32'h0001_2345; operand_b = 32'd777;
    @(posedge clock);                    // E0
    #1 valid = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort state", debug_state, ST_IDLE);
    check("abort stall", stall, 0);
    check("abort ready", ready, 0);
    check("abort result", result, 0);
    @(negedge clock);
    reset = 1'b0;
    run_op("mul 3*4 after reset", OP_MULT, 32'd3, 32'd4, 32'd12, 1'b0, 33, 33);

    idle_pattern("opcode0 valid", 1'b1, 5'd0, 6);
    idle_pattern("mult no valid", 1'b0, OP_MULT, 6);

    // Back-to-back: multiply then divide with valid held high.
    @(negedge clock);
    valid = 1'b1; opcode = OP_MULT; operand_a = 32'd7; operand_b = 32'hFFFF_FFFA;
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    t1 = cyc;
    check("b2b first result", result, 32'hFFFF_FFD6);
    opcode = OP_DIV; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clock);
    check("b2b accept stall", stall, 1);
    @(negedge clock);
    valid = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    t2 = cyc;
    check("b2b ready spacing", t2 - t1, 34);
    check("b2b second result", result, 32'd14);
    check("b2b second exception", exception, 0);
    repeat (2) @(negedge clock);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
